// File: rtl/axi_rd_arbiter_if.sv
// One AXI4 read address + read data channel pair.
// The master modport drives AR and RREADY; the slave modport drives ARREADY and R.
interface axi_rd_arbiter_if;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  modport master (
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  ARREADY, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output ARREADY, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 AR/R channel pair between the I-cache (S0, high priority) and the
// D-cache (S1, low priority). One burst outstanding; S1 starvation is bounded.
module axi_rd_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                   M_AXI_CLK,
  input  logic                   M_AXI_RSTN,
  axi_rd_arbiter_if.slave        S0,
  axi_rd_arbiter_if.slave        S1,
  axi_rd_arbiter_if.master       M_AXI,
  output logic [1:0]             GRANT,
  output logic                   BUSY,
  output logic                   ERR_LEN
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  state_e      state_q;
  logic [1:0]  grant_q;
  logic [31:0] araddr_q;
  logic [7:0]  arlen_q;
  logic [2:0]  arsize_q;
  logic [1:0]  arburst_q;
  logic        arvalid_q;
  logic [7:0]  beat_q;
  logic [3:0]  starve_q;
  logic        err_q;

  logic idle, in_data, s0_win, s1_win, own0, own1, r_hs;

  assign idle    = (state_q == StIdle);
  assign in_data = (state_q == StData);

  // S1 only overrides a competing S0 once it has been passed over StarveMax times.
  assign s1_win = idle && S1.ARVALID && (!S0.ARVALID || (starve_q == StarveMax));
  assign s0_win = idle && S0.ARVALID && !s1_win;

  assign S0.ARREADY = s0_win;
  assign S1.ARREADY = s1_win;

  assign own0 = in_data && grant_q[0];
  assign own1 = in_data && grant_q[1];

  // R path is pure steering: no added latency, non-owner sees all zeros.
  assign M_AXI.RREADY = (own0 && S0.RREADY) || (own1 && S1.RREADY);
  assign r_hs         = in_data && M_AXI.RVALID && M_AXI.RREADY;

  assign S0.RVALID = own0 && M_AXI.RVALID;
  assign S0.RDATA  = own0 ? M_AXI.RDATA : '0;
  assign S0.RRESP  = own0 ? M_AXI.RRESP : '0;
  assign S0.RLAST  = own0 && M_AXI.RLAST;

  assign S1.RVALID = own1 && M_AXI.RVALID;
  assign S1.RDATA  = own1 ? M_AXI.RDATA : '0;
  assign S1.RRESP  = own1 ? M_AXI.RRESP : '0;
  assign S1.RLAST  = own1 && M_AXI.RLAST;

  assign M_AXI.ARADDR  = araddr_q;
  assign M_AXI.ARLEN   = arlen_q;
  assign M_AXI.ARSIZE  = arsize_q;
  assign M_AXI.ARBURST = arburst_q;
  assign M_AXI.ARVALID = arvalid_q;

  assign GRANT   = grant_q;
  assign BUSY    = !idle;
  assign ERR_LEN = err_q;

  always_ff @(posedge M_AXI_CLK or negedge M_AXI_RSTN) begin
    if (!M_AXI_RSTN) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      arvalid_q <= 1'b0;
      beat_q    <= '0;
      starve_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (s1_win) begin
            araddr_q  <= S1.ARADDR;
            arlen_q   <= S1.ARLEN;
            arsize_q  <= S1.ARSIZE;
            arburst_q <= S1.ARBURST;
            grant_q   <= 2'b10;
            starve_q  <= '0;
            arvalid_q <= 1'b1;
            state_q   <= StAddr;
          end else if (s0_win) begin
            araddr_q  <= S0.ARADDR;
            arlen_q   <= S0.ARLEN;
            arsize_q  <= S0.ARSIZE;
            arburst_q <= S0.ARBURST;
            grant_q   <= 2'b01;
            if (S1.ARVALID && (starve_q != StarveMax)) begin
              starve_q <= starve_q + 4'd1;
            end
            arvalid_q <= 1'b1;
            state_q   <= StAddr;
          end
        end
        StAddr: begin
          if (M_AXI.ARREADY) begin
            arvalid_q <= 1'b0;
            beat_q    <= '0;
            state_q   <= StData;
          end
        end
        StData: begin
          if (r_hs) begin
            beat_q <= beat_q + 8'd1;
            // Flag both an early RLAST and a missing one; only RLAST ends the burst.
            if (M_AXI.RLAST != (beat_q == arlen_q)) begin
              err_q <= 1'b1;
            end
            if (M_AXI.RLAST) begin
              state_q <= StIdle;
              grant_q <= '0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: arbitration table plus hand-written burst,
// length-error, async-reset and back-to-back sequences.
module tb_axi_rd_arbiter;

  logic       clk;
  logic       rstn;
  logic [1:0] grant;
  logic       busy;
  logic       err_len;

  int n_checks;
  int n_err;

  axi_rd_arbiter_if s0_bus ();
  axi_rd_arbiter_if s1_bus ();
  axi_rd_arbiter_if m_bus ();

  axi_rd_arbiter #(
    .STARVE_LIMIT (4)
  ) dut (
    .M_AXI_CLK  (clk),
    .M_AXI_RSTN (rstn),
    .S0         (s0_bus),
    .S1         (s1_bus),
    .M_AXI      (m_bus),
    .GRANT      (grant),
    .BUSY       (busy),
    .ERR_LEN    (err_len)
  );

  typedef struct {
    bit         v0;
    bit         v1;
    logic [1:0] exp_grant;
  } arb_vec_t;

  arb_vec_t vecs [12];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present a request at the next negedge and follow it into the ADDR state.
  task automatic request(input bit v0, input bit v1, input logic [31:0] a0,
                         input logic [31:0] a1, input logic [7:0] len,
                         input logic [1:0] exp);
    @(negedge clk);
    s0_bus.ARADDR  = a0;   s0_bus.ARLEN  = len; s0_bus.ARSIZE = 3'd2;
    s0_bus.ARBURST = 2'b01; s0_bus.ARVALID = v0;
    s1_bus.ARADDR  = a1;   s1_bus.ARLEN  = len; s1_bus.ARSIZE = 3'd3;
    s1_bus.ARBURST = 2'b01; s1_bus.ARVALID = v1;
    #1;
    chk("arready", 32'({s1_bus.ARREADY, s0_bus.ARREADY}), 32'(exp));
    @(negedge clk);
    s0_bus.ARVALID = 1'b0;
    s1_bus.ARVALID = 1'b0;
    #1;
    chk("grant", 32'(grant), 32'(exp));
    chk("busy_addr", 32'(busy), 32'd1);
    chk("m_arvalid", 32'(m_bus.ARVALID), 32'd1);
    chk("m_araddr", m_bus.ARADDR, exp[1] ? a1 : a0);
    chk("m_arlen", 32'(m_bus.ARLEN), 32'(len));
    chk("m_arsize", 32'(m_bus.ARSIZE), exp[1] ? 32'd3 : 32'd2);
  endtask

  task automatic addr_phase(input int delay, input logic [31:0] a);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      #1;
      chk("arvalid_hold", 32'(m_bus.ARVALID), 32'd1);
      chk("araddr_hold", m_bus.ARADDR, a);
    end
    @(negedge clk);
    m_bus.ARREADY = 1'b1;
    @(negedge clk);
    m_bus.ARREADY = 1'b0;
    #1;
    chk("arvalid_drop", 32'(m_bus.ARVALID), 32'd0);
  endtask

  // Deliver n beats with RLAST on the n-th; non-owner RREADY held high as a decoy.
  task automatic beats(input int n, input logic [1:0] own, input bit toggle);
    int  k;
    int  cyc;
    bit  rdy;
    logic        ov, ol, nv;
    logic [31:0] od, nd;
    k   = 0;
    cyc = 0;
    while (k < n && cyc < 64) begin
      @(negedge clk);
      rdy = toggle ? (cyc % 2 == 0) : 1'b1;
      s0_bus.RREADY = own[0] ? rdy : 1'b1;
      s1_bus.RREADY = own[1] ? rdy : 1'b1;
      m_bus.RVALID  = 1'b1;
      m_bus.RDATA   = 32'hA000 + 32'(k);
      m_bus.RRESP   = 2'b00;
      m_bus.RLAST   = (k == n - 1);
      #1;
      ov = own[0] ? s0_bus.RVALID : s1_bus.RVALID;
      ol = own[0] ? s0_bus.RLAST  : s1_bus.RLAST;
      od = own[0] ? s0_bus.RDATA  : s1_bus.RDATA;
      nv = own[0] ? s1_bus.RVALID : s0_bus.RVALID;
      nd = own[0] ? s1_bus.RDATA  : s0_bus.RDATA;
      chk("m_rready", 32'(m_bus.RREADY), 32'(rdy));
      chk("own_rvalid", 32'(ov), 32'd1);
      chk("own_rdata", od, 32'hA000 + 32'(k));
      chk("own_rlast", 32'(ol), 32'(k == n - 1));
      chk("other_rvalid", 32'(nv), 32'd0);
      chk("other_rdata", nd, 32'd0);
      if (rdy) k++;
      cyc++;
    end
    chk("beats_done", 32'(k), 32'(n));
    @(negedge clk);
    m_bus.RVALID  = 1'b0;
    m_bus.RLAST   = 1'b0;
    s0_bus.RREADY = 1'b0;
    s1_bus.RREADY = 1'b0;
    #1;
    chk("busy_end", 32'(busy), 32'd0);
    chk("grant_end", 32'(grant), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    vecs[0]  = '{1'b1, 1'b1, 2'b01};
    vecs[1]  = '{1'b1, 1'b1, 2'b01};
    vecs[2]  = '{1'b1, 1'b1, 2'b01};
    vecs[3]  = '{1'b1, 1'b1, 2'b01};
    vecs[4]  = '{1'b1, 1'b1, 2'b10};
    vecs[5]  = '{1'b1, 1'b1, 2'b01};
    vecs[6]  = '{1'b0, 1'b1, 2'b10};
    vecs[7]  = '{1'b1, 1'b0, 2'b01};
    vecs[8]  = '{1'b1, 1'b1, 2'b01};
    vecs[9]  = '{1'b1, 1'b1, 2'b01};
    vecs[10] = '{1'b1, 1'b1, 2'b01};
    vecs[11] = '{1'b1, 1'b1, 2'b01};

    rstn = 1'b0;
    s0_bus.ARADDR = '0; s0_bus.ARLEN = '0; s0_bus.ARSIZE = '0; s0_bus.ARBURST = '0;
    s0_bus.ARVALID = 1'b0; s0_bus.RREADY = 1'b0;
    s1_bus.ARADDR = '0; s1_bus.ARLEN = '0; s1_bus.ARSIZE = '0; s1_bus.ARBURST = '0;
    s1_bus.ARVALID = 1'b0; s1_bus.RREADY = 1'b0;
    m_bus.ARREADY = 1'b0; m_bus.RDATA = '0; m_bus.RRESP = '0;
    m_bus.RLAST = 1'b0; m_bus.RVALID = 1'b0;

    #2;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_len), 32'd0);
    chk("rst_arvalid", 32'(m_bus.ARVALID), 32'd0);
    chk("rst_araddr", m_bus.ARADDR, 32'd0);
    chk("rst_rready", 32'(m_bus.RREADY), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Single S0 burst, slave ARREADY two cycles late.
    request(1'b1, 1'b0, 32'h1000, 32'h0, 8'd3, 2'b01);
    addr_phase(2, 32'h1000);
    beats(4, 2'b01, 1'b0);
    chk("err_after_ok", 32'(err_len), 32'd0);

    // S1 eight-beat burst with RREADY toggling.
    request(1'b0, 1'b1, 32'h0, 32'h1800, 8'd7, 2'b10);
    addr_phase(0, 32'h1800);
    beats(8, 2'b10, 1'b1);

    // Early RLAST on the third beat of an ARLEN=3 burst.
    request(1'b1, 1'b0, 32'h2000, 32'h0, 8'd3, 2'b01);
    addr_phase(0, 32'h2000);
    beats(3, 2'b01, 1'b0);
    chk("err_set", 32'(err_len), 32'd1);

    // Arbitration / starvation table, ARLEN=0 bursts.
    for (int i = 0; i < 12; i++) begin
      request(vecs[i].v0, vecs[i].v1, 32'h100 + 32'(i * 16), 32'h200 + 32'(i * 16),
              8'd0, vecs[i].exp_grant);
      addr_phase(0, vecs[i].exp_grant[1] ? 32'h200 + 32'(i * 16) : 32'h100 + 32'(i * 16));
      beats(1, vecs[i].exp_grant, 1'b0);
    end
    chk("err_sticky", 32'(err_len), 32'd1);

    // Async reset mid-DATA (beat 1 of 4) with starve count saturated beforehand.
    request(1'b1, 1'b0, 32'h3000, 32'h0, 8'd3, 2'b01);
    addr_phase(0, 32'h3000);
    @(negedge clk);
    s0_bus.RREADY = 1'b1;
    m_bus.RVALID = 1'b1; m_bus.RDATA = 32'hB000; m_bus.RLAST = 1'b0;
    @(negedge clk);
    m_bus.RDATA = 32'hB001;
    #1;
    chk("pre_rst_rvalid", 32'(s0_bus.RVALID), 32'd1);
    rstn = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_err", 32'(err_len), 32'd0);
    chk("arst_rready", 32'(m_bus.RREADY), 32'd0);
    chk("arst_s0_rvalid", 32'(s0_bus.RVALID), 32'd0);
    chk("arst_s0_rdata", s0_bus.RDATA, 32'd0);
    chk("arst_araddr", m_bus.ARADDR, 32'd0);
    m_bus.RVALID = 1'b0;
    s0_bus.RREADY = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    // starve count cleared by reset, so S0 wins a contested request
    request(1'b1, 1'b1, 32'h4000, 32'h5000, 8'd0, 2'b01);
    addr_phase(0, 32'h4000);
    beats(1, 2'b01, 1'b0);
    request(1'b0, 1'b1, 32'h0, 32'h5000, 8'd0, 2'b10);
    addr_phase(0, 32'h5000);
    beats(1, 2'b10, 1'b0);

    // S0 request arriving with the last beat of an S1 burst.
    request(1'b0, 1'b1, 32'h0, 32'h6000, 8'd0, 2'b10);
    addr_phase(0, 32'h6000);
    @(negedge clk);
    s1_bus.RREADY = 1'b1;
    m_bus.RVALID = 1'b1; m_bus.RDATA = 32'h6666; m_bus.RLAST = 1'b1;
    s0_bus.ARADDR = 32'h7000; s0_bus.ARLEN = 8'd0; s0_bus.ARSIZE = 3'd2;
    s0_bus.ARVALID = 1'b1;
    #1;
    chk("s0_arready_in_data", 32'(s0_bus.ARREADY), 32'd0);
    chk("s1_last_rvalid", 32'(s1_bus.RVALID), 32'd1);
    @(negedge clk);
    m_bus.RVALID = 1'b0; m_bus.RLAST = 1'b0; s1_bus.RREADY = 1'b0;
    #1;
    chk("s0_arready_next", 32'(s0_bus.ARREADY), 32'd1);
    chk("grant_bubble", 32'(grant), 32'd0);
    @(negedge clk);
    s0_bus.ARVALID = 1'b0;
    #1;
    chk("grant_s0_b2b", 32'(grant), 32'd1);
    chk("araddr_b2b", m_bus.ARADDR, 32'h7000);
    addr_phase(0, 32'h7000);
    beats(1, 2'b01, 1'b0);
    chk("err_final", 32'(err_len), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
